// File: rtl/uart_tx.sv
// uart_tx: serial transmitter for the lab serial link.
// Bytes arrive over a valid/ready handshake into a one-entry hold register,
// are moved into a shift register and sent as start bit, data bits LSB first,
// optional even parity bit and one or two stop bits. serial_out, busy and
// tx_done are registered from the current state, so the line trails the
// state register by one clock.
module uart_tx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;
  logic [DATA_BITS-1:0] hold_reg;
  logic                 hold_full;
  logic                 bit_end;

  assign tx_ready = !hold_full && !rst;
  assign bit_end  = (bit_cnt == CNT_LAST);

  // Frame sequencer, hold buffer and registered line outputs in one process.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      hold_reg   <= '0;
      hold_full  <= 1'b0;
      serial_out <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      busy    <= (state != IDLE);
      tx_done <= 1'b0;

      case (state)
        START:   serial_out <= 1'b0;
        DATA:    serial_out <= shift_reg[0];
        PARITY:  serial_out <= parity_bit;
        default: serial_out <= 1'b1;
      endcase

      if (state == IDLE || bit_end) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          bit_idx <= '0;
          if (hold_full) begin
            shift_reg  <= hold_reg;
            parity_bit <= ^hold_reg;
            hold_full  <= 1'b0;
            state      <= START;
          end
        end

        START: begin
          if (bit_end) begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            bit_idx <= '0;
            state   <= STOP;
          end
        end

        STOP: begin
          if (bit_end) begin
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              tx_done <= 1'b1;
              if (hold_full) begin
                shift_reg  <= hold_reg;
                parity_bit <= ^hold_reg;
                hold_full  <= 1'b0;
                state      <= START;
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end

        default: begin
          bit_idx <= '0;
          state   <= IDLE;
        end
      endcase

      // A new byte written here wins over the hold_full clear of a same-edge load.
      if (tx_valid && tx_ready) begin
        hold_reg  <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// One instance uses the default 8N1 setup and is watched by a frame decoder
// feeding a byte scoreboard; a second instance runs 8 data bits, even parity
// and two stop bits.
module tb_uart_tx;

  logic       tb_clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       serial_out;
  logic       busy;
  logic       tx_done;

  logic [7:0] p_tx_data;
  logic       p_tx_valid;
  logic       p_tx_ready;
  logic       p_serial_out;
  logic       p_busy;
  logic       p_tx_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] levels;
  } vec_t;

  vec_t vecs[4];

  uart_tx #(
    .CLKS_PER_BIT(10), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)
  ) dut (
    .clk(tb_clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .serial_out(serial_out), .busy(busy), .tx_done(tx_done)
  );

  uart_tx #(
    .CLKS_PER_BIT(10), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(2)
  ) dut_p (
    .clk(tb_clk), .rst(rst), .tx_data(p_tx_data), .tx_valid(p_tx_valid),
    .tx_ready(p_tx_ready), .serial_out(p_serial_out), .busy(p_busy), .tx_done(p_tx_done)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Free-running cycle count used to timestamp frame starts.
  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge tb_clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Waits for the block to be ready (bounded), then offers one byte for one cycle.
  task automatic applyStimulus(input logic [7:0] data);
    int waited;
    waited = 0;
    while (!tx_ready && waited < 1000) begin
      @(negedge tb_clk);
      waited++;
    end
    checkOutput("stim_ready", {31'd0, tx_ready}, 32'd1);
    if (tx_ready) begin
      tx_data  = data;
      tx_valid = 1'b1;
      exp_q.push_back(data);
      @(negedge tb_clk);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
    end
  endtask

  task automatic waitIdle(input string name);
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || busy) && waited < 2000) begin
      @(negedge tb_clk);
      waited++;
    end
    checkOutput(name, exp_q.size(), 32'd0);
  endtask

  task automatic monWait(input int n, output bit saw_rst);
    saw_rst = 1'b0;
    repeat (n) begin
      @(negedge tb_clk);
      if (rst) saw_rst = 1'b1;
    end
  endtask

  // Frame decoder for the default instance: samples mid-bit and scores each byte.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] want;
    logic       start_lvl;
    logic       stop_lvl;
    bit         saw;
    bit         ok_frame;
    forever begin
      @(negedge tb_clk);
      if (!rst && serial_out === 1'b0) begin
        start_q.push_back(cyc);
        ok_frame = 1'b1;
        got      = '0;
        monWait(4, saw);
        if (saw) ok_frame = 1'b0;
        start_lvl = serial_out;
        for (int b = 0; b < 8; b++) begin
          monWait(10, saw);
          if (saw) ok_frame = 1'b0;
          got[b] = serial_out;
        end
        monWait(10, saw);
        if (saw) ok_frame = 1'b0;
        stop_lvl = serial_out;
        if (ok_frame) begin
          checkOutput("sb_start_bit", {31'd0, start_lvl}, 32'd0);
          checkOutput("sb_stop_bit", {31'd0, stop_lvl}, 32'd1);
          checkOutput("sb_byte_pending", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            checkOutput("sb_data", {24'd0, got}, {24'd0, want});
          end
        end
      end
    end
  end

  // Main test sequence.
  initial begin : main
    int lvl_err;
    int done_cnt;
    int done_at;
    int busy_cnt;
    int stop_high;
    int bad;
    int s0;
    int s1;
    int waited;
    logic par_sample;
    logic [11:0] exp12;

    vecs[0] = '{data: 8'hA5, levels: 10'b1101001010};
    vecs[1] = '{data: 8'h3C, levels: 10'b1001111000};
    vecs[2] = '{data: 8'h81, levels: 10'b1100000010};
    vecs[3] = '{data: 8'h5A, levels: 10'b1010110100};
    exp12   = 12'b111000001110;

    // Reset with a valid byte presented.
    rst        = 1'b1;
    tx_valid   = 1'b1;
    tx_data    = 8'hFF;
    p_tx_valid = 1'b0;
    p_tx_data  = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge tb_clk);
      checkOutput("rst_serial_out", {31'd0, serial_out}, 32'd1);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_tx_done", {31'd0, tx_done}, 32'd0);
      checkOutput("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    end
    rst      = 1'b0;
    tx_valid = 1'b0;
    tick(1);
    checkOutput("rst_ready_after", {31'd0, tx_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (serial_out !== 1'b1 || busy !== 1'b0) bad++;
      tick(1);
    end
    checkOutput("rst_no_frame", bad, 32'd0);

    // Single frames from the vector table, checked cycle by cycle.
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].data);
      tick(1);
      checkOutput($sformatf("v%0d_latency_line", v), {31'd0, serial_out}, 32'd1);
      tick(1);
      lvl_err  = 0;
      done_cnt = 0;
      done_at  = -1;
      busy_cnt = 0;
      for (int c = 0; c < 100; c++) begin
        if (serial_out !== vecs[v].levels[c / 10]) lvl_err++;
        if (tx_done === 1'b1) begin
          done_cnt++;
          done_at = c;
        end
        if (busy === 1'b1) busy_cnt++;
        tick(1);
      end
      checkOutput($sformatf("v%0d_levels", v), lvl_err, 32'd0);
      checkOutput($sformatf("v%0d_done_count", v), done_cnt, 32'd1);
      checkOutput($sformatf("v%0d_done_cycle", v), done_at, 32'd99);
      checkOutput($sformatf("v%0d_busy_cycles", v), busy_cnt, 32'd100);
      checkOutput($sformatf("v%0d_busy_after", v), {31'd0, busy}, 32'd0);
      checkOutput($sformatf("v%0d_line_after", v), {31'd0, serial_out}, 32'd1);
    end
    waitIdle("vec_drain");

    // Back-to-back frames: 8'hFF accepted during the first start bit.
    start_q.delete();
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    bad = 0;
    for (int k = 0; k < 99; k++) begin
      if (tx_ready !== 1'b0) bad++;
      tick(1);
    end
    checkOutput("b2b_ready_low", bad, 32'd0);
    checkOutput("b2b_ready_back", {31'd0, tx_ready}, 32'd1);
    waited = 0;
    while (start_q.size() < 2 && waited < 300) begin
      tick(1);
      waited++;
    end
    checkOutput("b2b_start_count", start_q.size(), 32'd2);
    if (start_q.size() >= 2) begin
      s0 = start_q.pop_front();
      s1 = start_q.pop_front();
      checkOutput("b2b_period", s1 - s0, 32'd100);
    end
    waitIdle("b2b_drain");

    // Parity instance: 8'h07 with even parity and two stop bits.
    checkOutput("par_ready", {31'd0, p_tx_ready}, 32'd1);
    p_tx_data  = 8'h07;
    p_tx_valid = 1'b1;
    tick(1);
    p_tx_valid = 1'b0;
    tick(1);
    checkOutput("par_latency_line", {31'd0, p_serial_out}, 32'd1);
    tick(1);
    lvl_err    = 0;
    done_cnt   = 0;
    done_at    = -1;
    busy_cnt   = 0;
    stop_high  = 0;
    par_sample = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (p_serial_out !== exp12[c / 10]) lvl_err++;
      if (p_tx_done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (p_busy === 1'b1) busy_cnt++;
      if (c >= 100 && p_serial_out === 1'b1) stop_high++;
      if (c == 95) par_sample = p_serial_out;
      tick(1);
    end
    checkOutput("par_levels", lvl_err, 32'd0);
    checkOutput("par_bit", {31'd0, par_sample}, 32'd1);
    checkOutput("par_stop_high", stop_high, 32'd20);
    checkOutput("par_busy_cycles", busy_cnt, 32'd120);
    checkOutput("par_done_count", done_cnt, 32'd1);
    checkOutput("par_done_cycle", done_at, 32'd119);
    checkOutput("par_busy_after", {31'd0, p_busy}, 32'd0);

    // Reset during data bit 3 of 8'h3C with a second byte held.
    applyStimulus(8'h3C);
    applyStimulus(8'h96);
    tick(44);
    rst = 1'b1;
    tick(1);
    checkOutput("midrst_line", {31'd0, serial_out}, 32'd1);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_ready", {31'd0, tx_ready}, 32'd0);
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    tick(1);
    checkOutput("midrst_hold_cleared", {31'd0, tx_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (serial_out !== 1'b1 || busy !== 1'b0) bad++;
      tick(1);
    end
    checkOutput("midrst_no_frame", bad, 32'd0);

    // Valid presented while the hold register is full is ignored.
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_ready !== 1'b0) bad++;
      tick(1);
    end
    tx_valid = 1'b0;
    checkOutput("ignored_ready_low", bad, 32'd0);
    waitIdle("ignored_drain");
    tick(50);
    checkOutput("final_queue_empty", exp_q.size(), 32'd0);
    checkOutput("final_line_idle", {31'd0, serial_out}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
